// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : UART transmitter. Sends one byte per request as start bit,
//             eight data bits LSB-first, optional even parity bit and one
//             stop bit. Each bit lasts CLK_HZ/BAUD clock cycles.
//  Options  : define UART_TX_PARITY_EN to add the even-parity bit
//             (11-bit frame); leave it undefined for 8N1 (10-bit frame).
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
  parameter int CLK_HZ = 48000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_out
);

  // Cycles per bit. A divider of 1 still needs a 1-bit counter, so the
  // width is clamped to at least one bit.
  localparam int              DIV      = CLK_HZ / BAUD;
  localparam int              CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       idx;
  logic [2:0]       idx_next;
  logic [7:0]       data_reg;
  logic [7:0]       data_next;
  logic             bit_last;
  logic             out_next;
  logic             busy_next;
  logic             done_next;

  // The current bit period ends when the baud counter reaches DIV-1.
  assign bit_last = (cnt == CNT_LAST);

  // Next-state logic: the counter restarts on every state entry (and on each
  // new data bit), and the byte is captured only when leaving IDLE so that
  // requests made mid-frame cannot disturb it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    idx_next   = idx;
    data_next  = data_reg;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (tx_start) begin
          data_next  = tx_data;
          state_next = START;
        end
      end
      START: begin
        if (bit_last) begin
          cnt_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_last) begin
          cnt_next = '0;
          // Index wraps 7 -> 0 on the way out, ready for the next frame.
          idx_next = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_last) begin
          cnt_next   = '0;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_last) begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Output decode from the *next* state so the outputs can be registered
  // without adding a cycle of latency: the line level, busy flag and done
  // pulse all change on the same edge as the state they belong to.
  always_comb begin
    out_next  = 1'b1;
    busy_next = (state_next != IDLE);
    done_next = (state_next == STOP) && (cnt_next == CNT_LAST);
    case (state_next)
      IDLE:    out_next = 1'b1;
      START:   out_next = 1'b0;
      DATA:    out_next = data_next[idx_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  out_next = ^data_next;
`endif
      STOP:    out_next = 1'b1;
      default: out_next = 1'b1;
    endcase
  end

  // State and output registers; reset aborts any frame in flight and
  // overrides a simultaneous start request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= 3'd0;
      data_reg <= 8'h00;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      idx      <= idx_next;
      data_reg <= data_next;
      tx_out   <= out_next;
      tx_busy  <= busy_next;
      tx_done  <= done_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Self-checking bench for uart_tx at CLK_HZ=16, BAUD=1 (16
//             cycles per bit). Frame expectations follow UART_TX_PARITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_out;

  int checks = 0;
  int errors = 0;

  uart_tx #(
    .CLK_HZ(16),
    .BAUD  (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx_out  (tx_out)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // One frame request: the byte, the hand-written 11-bit line sequence in
  // send order (bit0 = start, bits1..8 = data LSB-first, bit9 = even parity,
  // bit10 = stop), idle cycles before the request, and the frame cycle at
  // which a stray 0xFF request is injected (0 = none).
  typedef struct {
    logic [7:0]  data;
    logic [10:0] seq;
    int          gap;
    int          inj;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected line level in frame cycle k (1-based); without parity the
  // stop bit directly follows data bit 7.
  function automatic logic exp_bit(input logic [10:0] seq, input int k);
    int p;
    p = (k - 1) / DIV;
    if (NB == 10 && p == 9) return seq[10];
    return seq[p];
  endfunction

  // Called at a falling edge with the DUT idle; returns at the falling edge
  // of the first idle cycle after the frame, so a following call starts
  // back-to-back.
  task automatic send_frame(input vec_t v);
    tx_data  = v.data;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      chk($sformatf("tx_out %02h c%0d", v.data, k), 32'(tx_out), 32'(exp_bit(v.seq, k)));
      chk($sformatf("tx_busy %02h c%0d", v.data, k), 32'(tx_busy), 32'd1);
      chk($sformatf("tx_done %02h c%0d", v.data, k), 32'(tx_done), 32'(k == FRAME));
      if (k == v.inj) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk);
    end
    tx_start = 1'b0;
    chk($sformatf("idle tx_out %02h", v.data), 32'(tx_out), 32'd1);
    chk($sformatf("idle tx_busy %02h", v.data), 32'(tx_busy), 32'd0);
    chk($sformatf("idle tx_done %02h", v.data), 32'(tx_done), 32'd0);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, seq: 11'b1_0_10100101_0, gap: 2, inj: 0};
    vecs[1] = '{data: 8'h3C, seq: 11'b1_0_00111100_0, gap: 3, inj: 40};
    vecs[2] = '{data: 8'h01, seq: 11'b1_1_00000001_0, gap: 5, inj: 0};
    vecs[3] = '{data: 8'h80, seq: 11'b1_1_10000000_0, gap: 0, inj: 0};
    vecs[4] = '{data: 8'h00, seq: 11'b1_0_00000000_0, gap: 1, inj: 0};
    vecs[5] = '{data: 8'hFF, seq: 11'b1_0_11111111_0, gap: 0, inj: 0};

    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset tx_out", 32'(tx_out), 32'd1);
    chk("reset tx_busy", 32'(tx_busy), 32'd0);
    chk("reset tx_done", 32'(tx_done), 32'd0);
    rst = 1'b0;

    // Quiet line after reset.
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      chk($sformatf("idle50 tx_out c%0d", c), 32'(tx_out), 32'd1);
      chk($sformatf("idle50 tx_busy c%0d", c), 32'(tx_busy), 32'd0);
      chk($sformatf("idle50 tx_done c%0d", c), 32'(tx_done), 32'd0);
    end

    // Table: plain frames, ignored mid-frame request, back-to-back pairs.
    for (int i = 0; i < 6; i++) begin
      repeat (vecs[i].gap) @(negedge clk);
      send_frame(vecs[i]);
    end

    // Reset in the middle of a 0x55 frame (cycle 70 is inside data bit 3, a 0).
    repeat (2) @(negedge clk);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      chk($sformatf("abort tx_out c%0d", k), 32'(tx_out), 32'(exp_bit(11'b1_0_01010101_0, k)));
      if (k < 70) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort c71 tx_out", 32'(tx_out), 32'd1);
    chk("abort c71 tx_busy", 32'(tx_busy), 32'd0);
    chk("abort c71 tx_done", 32'(tx_done), 32'd0);
    for (int c = 1; c <= FRAME + DIV; c++) begin
      @(negedge clk);
      chk($sformatf("abort after tx_out c%0d", c), 32'(tx_out), 32'd1);
      chk($sformatf("abort after tx_done c%0d", c), 32'(tx_done), 32'd0);
      chk($sformatf("abort after tx_busy c%0d", c), 32'(tx_busy), 32'd0);
    end

    // Reset and start together: reset wins, nothing is sent.
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    tx_start = 1'b0;
    for (int c = 1; c <= 3 * DIV; c++) begin
      chk($sformatf("rst+start tx_busy c%0d", c), 32'(tx_busy), 32'd0);
      chk($sformatf("rst+start tx_out c%0d", c), 32'(tx_out), 32'd1);
      @(negedge clk);
    end

    // Normal operation resumes after the aborted frames.
    send_frame(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have the parameter CLK_HZ, default 48000000, giving the input clock frequency in Hz.
REQ-002 The block SHALL have the parameter BAUD, default 9600, giving the serial bit rate in bits/s.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port tx_data, input, 8 bits: the byte to send.
REQ-006 The block SHALL have port tx_start, input, 1 bit: request to send tx_data.
REQ-007 The block SHALL have port tx_busy, output, 1 bit: high while a frame is in progress.
REQ-008 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-009 The block SHALL have port tx_out, output, 1 bit: the serial line, idle high; it feeds the receiver's DATA_IN.

Function
REQ-010 Bit period SHALL be DIV = CLK_HZ/BAUD clk cycles (integer division); the baud counter SHALL be $clog2(DIV) bits wide and SHALL restart at 0 on every state entry.
REQ-011 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-012 In IDLE, with tx_start=1 at a rising edge, the block SHALL latch tx_data into a shift register and enter START; tx_out SHALL be 0 and tx_busy SHALL be 1 from the next cycle on.
REQ-013 tx_start SHALL be ignored while tx_busy=1; no queueing, and the latched byte SHALL NOT change mid-frame.
REQ-014 START SHALL hold tx_out=0 for DIV cycles and then go to DATA.
REQ-015 DATA SHALL send 8 bits LSB-first, DIV cycles each, using a 3-bit index that wraps 7->0 on exit.
REQ-016 After bit 7, DATA SHALL go to PARITY if parity is compiled in (REQ-025), otherwise to STOP.
REQ-017 PARITY SHALL drive the even-parity bit (XOR of the latched byte) for DIV cycles and then go to STOP.
REQ-018 STOP SHALL drive tx_out=1 for DIV cycles.
REQ-019 On the last STOP cycle the block SHALL pulse tx_done=1 for exactly one cycle and return to IDLE, with tx_busy=0 on the following cycle.
REQ-020 If tx_start=1 in the first IDLE cycle after tx_done, a new frame SHALL begin without a gap; back-to-back frames SHALL be legal.
REQ-021 tx_out SHALL come directly from a register (no combinational glitches).

Reset
REQ-022 With rst=1 at a rising edge, the block SHALL set state=IDLE, tx_out=1, tx_busy=0, tx_done=0, and clear the baud counter, bit index and shift register.
REQ-023 Reset in mid-frame SHALL abort the frame immediately: tx_out=1 on the next cycle and no tx_done pulse.
REQ-024 When rst and tx_start are high in the same cycle, reset SHALL win.

Configuration
REQ-025 With macro UART_TX_PARITY_EN defined, the block SHALL include the PARITY state: 11-bit frame (start, 8 data, even parity, stop), matching the receiver's parity check.
REQ-026 With UART_TX_PARITY_EN undefined, the block SHALL omit the PARITY state and its logic: 10-bit frame (8N1).

Verification (CLK_HZ=16, BAUD=1, so DIV=16)
REQ-027 Reset, then idle for 50 cycles -> tx_out=1, tx_busy=0 and tx_done=0 throughout.
REQ-028 tx_data=0xA5 with a 1-cycle tx_start, UART_TX_PARITY_EN defined -> tx_out sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each held 16 cycles; tx_done at cycle 176; tx_busy high for 176 cycles.
REQ-029 Same stimulus, macro undefined -> 10 bits with no parity bit; tx_done at cycle 160.
REQ-030 Send 0x3C, pulse tx_start with 0xFF at cycle 40 -> the 0xFF request is ignored; only the 0x3C frame appears (parity bit 0).
REQ-031 Back-to-back 0x01 then 0x80, with the second tx_start in the cycle after tx_done -> no idle gap between the frames; parity bits 1 and 1.
REQ-032 Assert rst at cycle 70 of a 0x55 frame -> tx_out=1 at cycle 71, tx_busy=0, and no tx_done pulse.
